// File: rtl/nor_flash_pkg.sv
// Shared definitions for the NOR flash read sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package nor_flash_pkg;

    // Sequencer states: idle, first flash word, second flash word, result held
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD0  = 2'd1,
        RD1  = 2'd2,
        DONE = 2'd3
    } nf_state_e;

    // Width of the access wait counter (covers ACCESS_CYCLES up to 15)
    localparam int NF_WAIT_W = 4;

endpackage

// File: rtl/nf_wait_timer.sv
// Loadable down-counter timing one flash word access; tc_o flags the last cycle.
// Latency: tc_o rises load_val_i cycles after the load edge.
// Backpressure: none; a load always restarts the count.
module nf_wait_timer
    import nor_flash_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 load_i,
    input  logic [NF_WAIT_W-1:0] load_val_i,
    output logic                 tc_o
);

    logic [NF_WAIT_W-1:0] cnt_q;

    // Count down to zero after each load, then rest at zero
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/nor_flash_rd_seq.sv
// Read sequencer for a x16 parallel NOR flash; optional last-word hit via NOR_FLASH_LAST_WORD_HIT_EN.
// Latency: ACCESS_CYCLES+1 (byte/even word), 2*ACCESS_CYCLES+1 (odd word), 1 on a last-word hit.
// Backpressure: enable is a level held by the requester; ready stays high until enable drops or the request changes.
module nor_flash_rd_seq
    import nor_flash_pkg::*;
#(
    parameter int         ACCESS_CYCLES = 4,
    parameter logic [4:0] BASE_HI       = 5'h00
) (
    input  logic        sys_clk,
    input  logic        reset,
    input  logic [16:0] addr,
    input  logic        byte_m,
    input  logic        enable,
    output logic [15:0] rd_data,
    output logic        ready,
    output logic [21:1] NF_A,
    input  logic [15:0] NF_D,
    output logic        NF_CE,
    output logic        NF_OE,
    output logic        NF_WE,
    output logic        NF_BYTE
);

    localparam logic [NF_WAIT_W-1:0] WAIT_LAST = NF_WAIT_W'(ACCESS_CYCLES - 1);

    nf_state_e   state_q;
    logic [16:0] addr_q;
    logic        byte_q;
    logic [15:0] w0_q;
    logic [15:0] w1_q;
    logic [15:0] rd_data_q;
    logic        ready_q;
    logic        pend_q;      // DONE entered, result not yet assembled
    logic        ce_n_q;
    logic        oe_n_q;
    logic [21:1] nf_a_q;

    logic        odd_wd;
    logic        req_new;
    logic        start_go;
    logic        tmr_load;
    logic        tmr_tc;
    logic        hit;
    logic [15:0] hit_w;
    logic [15:0] rd_data_d;

`ifdef NOR_FLASH_LAST_WORD_HIT_EN
    logic        hit_vld_q;
    logic [15:0] hit_wa_q;
    logic [15:0] hit_w_q;

    // Remember the most recent word fetched from the flash and where it came from
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            hit_vld_q <= 1'b0;
            hit_wa_q  <= '0;
            hit_w_q   <= '0;
        end else if (tmr_tc && state_q == RD0) begin
            hit_vld_q <= 1'b1;
            hit_wa_q  <= addr_q[16:1];
            hit_w_q   <= NF_D;
        end else if (tmr_tc && state_q == RD1) begin
            hit_vld_q <= 1'b1;
            hit_wa_q  <= addr_q[16:1] + 16'd1;
            hit_w_q   <= NF_D;
        end
    end

    // Odd words span two flash words, so they never short-circuit
    assign hit   = hit_vld_q && (hit_wa_q == addr[16:1]) && (byte_m || !addr[0]);
    assign hit_w = hit_w_q;
`else
    assign hit   = 1'b0;
    assign hit_w = '0;
`endif

    // Request decode, timer restart and byte-lane steering of the result
    always_comb begin
        odd_wd   = !byte_q && addr_q[0];
        req_new  = ({addr, byte_m} != {addr_q, byte_q});
        start_go = enable && ((state_q == IDLE) ||
                              (state_q == DONE && !pend_q && req_new));
        tmr_load = (start_go && !hit) || (state_q == RD0 && tmr_tc && odd_wd);
        if (byte_q) begin
            rd_data_d = {8'h00, addr_q[0] ? w0_q[15:8] : w0_q[7:0]};
        end else if (!addr_q[0]) begin
            rd_data_d = w0_q;
        end else begin
            rd_data_d = {w1_q[7:0], w0_q[15:8]};
        end
    end

    nf_wait_timer u_wait (
        .clk_i      (sys_clk),
        .rst_i      (reset),
        .load_i     (tmr_load),
        .load_val_i (WAIT_LAST),
        .tc_o       (tmr_tc)
    );

    // Sequencer FSM: latch request, run one or two flash cycles, hold result
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            byte_q    <= 1'b0;
            w0_q      <= '0;
            w1_q      <= '0;
            rd_data_q <= '0;
            ready_q   <= 1'b0;
            pend_q    <= 1'b0;
            ce_n_q    <= 1'b1;
            oe_n_q    <= 1'b1;
            nf_a_q    <= '0;
        end else if (start_go) begin
            addr_q  <= addr;
            byte_q  <= byte_m;
            ready_q <= 1'b0;
            if (hit) begin
                w0_q    <= hit_w;
                pend_q  <= 1'b1;
                state_q <= DONE;
            end else begin
                nf_a_q  <= {BASE_HI, addr[16:1]};
                ce_n_q  <= 1'b0;
                oe_n_q  <= 1'b0;
                state_q <= RD0;
            end
        end else begin
            case (state_q)
                RD0: begin
                    if (tmr_tc) begin
                        w0_q <= NF_D;
                        if (odd_wd) begin
                            // Second word follows with CE/OE kept low; wraps within the window
                            nf_a_q  <= {BASE_HI, addr_q[16:1] + 16'd1};
                            state_q <= RD1;
                        end else begin
                            ce_n_q  <= 1'b1;
                            oe_n_q  <= 1'b1;
                            pend_q  <= 1'b1;
                            state_q <= DONE;
                        end
                    end
                end
                RD1: begin
                    if (tmr_tc) begin
                        w1_q    <= NF_D;
                        ce_n_q  <= 1'b1;
                        oe_n_q  <= 1'b1;
                        pend_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (pend_q) begin
                        rd_data_q <= rd_data_d;
                        ready_q   <= 1'b1;
                        pend_q    <= 1'b0;
                    end else if (!enable) begin
                        ready_q <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign rd_data = rd_data_q;
    assign ready   = ready_q;
    assign NF_A    = nf_a_q;
    assign NF_CE   = ce_n_q;
    assign NF_OE   = oe_n_q;
    assign NF_WE   = 1'b1;
    assign NF_BYTE = 1'b1;

endmodule

// File: tb/tb_nor_flash_rd_seq.sv
// Bench for nor_flash_rd_seq: table vectors, random reads against a request-level model, handshake/reset sequences.
// Latency: n/a.
// Backpressure: n/a.
module tb_nor_flash_rd_seq;

    localparam int         AC   = 4;
    localparam logic [4:0] BASE = 5'h03;   // non-zero window so the high address bits are visible
`ifdef NOR_FLASH_LAST_WORD_HIT_EN
    localparam bit HIT_EN = 1'b1;
`else
    localparam bit HIT_EN = 1'b0;
`endif

    logic        sys_clk = 1'b0;
    logic        reset;
    logic [16:0] addr;
    logic        byte_m;
    logic        enable;
    logic [15:0] rd_data;
    logic        ready;
    logic [20:0] NF_A;
    logic [15:0] NF_D;
    logic        NF_CE, NF_OE, NF_WE, NF_BYTE;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 sys_clk = ~sys_clk;

    nor_flash_rd_seq #(.ACCESS_CYCLES(AC), .BASE_HI(BASE)) dut (
        .sys_clk (sys_clk),
        .reset   (reset),
        .addr    (addr),
        .byte_m  (byte_m),
        .enable  (enable),
        .rd_data (rd_data),
        .ready   (ready),
        .NF_A    (NF_A),
        .NF_D    (NF_D),
        .NF_CE   (NF_CE),
        .NF_OE   (NF_OE),
        .NF_WE   (NF_WE),
        .NF_BYTE (NF_BYTE)
    );

    // Flash model: data is only valid once CE/OE have been low with a stable address for AC cycles
    logic [15:0] mem [0:65535];
    int          acc_cnt = 0;
    logic [20:0] a_last  = '0;

    always @(posedge sys_clk) begin
        if (!NF_CE && !NF_OE) acc_cnt <= (NF_A == a_last) ? acc_cnt + 1 : 1;
        else                  acc_cnt <= 0;
        a_last <= NF_A;
    end

    assign NF_D = (!NF_CE && !NF_OE && NF_A == a_last && NF_A[20:16] == BASE && acc_cnt >= AC - 1)
                  ? mem[NF_A[15:0]] : 16'hBAD0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Request-level reference: last-word store (used only when the hit feature is built in)
    bit          m_vld = 1'b0;
    logic [15:0] m_wa  = '0;
    logic [15:0] m_w   = '0;

    task automatic model_expect(input logic [16:0] a, input logic bm, output logic [15:0] d,
                                output int lat, output int ce, output logic [20:0] a0,
                                output logic [20:0] a1, output bit two);
        logic [15:0] wa, wn, w0, w1;
        bit odd;
        wa  = a[16:1];
        wn  = wa + 16'd1;
        odd = !bm && a[0];
        if (HIT_EN && !odd && m_vld && m_wa == wa) begin
            w0 = m_w; lat = 1; ce = 0;
        end else begin
            w0 = mem[wa]; lat = odd ? 2 * AC + 1 : AC + 1; ce = odd ? 2 * AC : AC;
        end
        w1 = mem[wn];
        if (bm)         d = {8'h00, a[0] ? w0[15:8] : w0[7:0]};
        else if (!a[0]) d = w0;
        else            d = {w1[7:0], w0[15:8]};
        a0  = {BASE, wa};
        a1  = {BASE, wn};
        two = odd;
        if (odd) begin m_w = w1; m_wa = wn; end
        else     begin m_w = w0; m_wa = wa; end
        m_vld = 1'b1;
    endtask

    // Issue one request, watch the flash pins until ready, compare against the model
    task automatic run_read(input string tag, input logic [16:0] a, input logic bm,
                            input bit keep_en, output logic [15:0] exp_d);
        int lat, ce, k, ce_cnt, runs, oe_bad;
        logic [20:0] a0, a1, s0, s1;
        bit two, got, prev_ce;
        model_expect(a, bm, exp_d, lat, ce, a0, a1, two);
        @(negedge sys_clk);
        addr = a; byte_m = bm; enable = 1'b1;
        k = 0; got = 0; ce_cnt = 0; runs = 0; oe_bad = 0; prev_ce = 1'b1; s0 = '0; s1 = '0;
        for (int c = 0; c < 60; c++) begin
            @(posedge sys_clk); #1;
            k++;
            if (NF_OE !== NF_CE) oe_bad++;
            if (!NF_CE) begin
                ce_cnt++;
                if (prev_ce) runs++;
                if (ce_cnt == 1)      s0 = NF_A;
                if (ce_cnt == AC + 1) s1 = NF_A;
            end
            prev_ce = NF_CE;
            if (ready) begin got = 1; break; end
        end
        chk({tag, " ready_seen"}, 32'(got), 32'd1);
        chk({tag, " rd_data"}, 32'(rd_data), 32'(exp_d));
        chk({tag, " latency"}, 32'(k - 1), 32'(lat));
        chk({tag, " ce_cycles"}, 32'(ce_cnt), 32'(ce));
        chk({tag, " ce_runs"}, 32'(runs), (ce > 0) ? 32'd1 : 32'd0);
        chk({tag, " oe_follows_ce"}, 32'(oe_bad), 32'd0);
        if (ce > 0) chk({tag, " nf_a_first"}, 32'(s0), 32'(a0));
        if (ce > 0 && two) chk({tag, " nf_a_second"}, 32'(s1), 32'(a1));
        if (!keep_en) begin
            @(negedge sys_clk);
            enable = 1'b0;
            @(posedge sys_clk); #1;
            chk({tag, " ready_drop"}, 32'(ready), 32'd0);
            chk({tag, " idle_ce"}, 32'(NF_CE), 32'd1);
            chk({tag, " idle_data"}, 32'(rd_data), 32'(exp_d));
        end
    endtask

    typedef struct {
        logic [16:0] a;
        logic        bm;
        bit          set0;
        logic [15:0] wa0;
        logic [15:0] d0;
        bit          set1;
        logic [15:0] wa1;
        logic [15:0] d1;
        logic [15:0] exp;
    } vec_t;

    vec_t tbl [8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        logic [15:0] ed, ed2;
        logic [16:0] ra;
        logic        rb;
        int          k;
        bit          got;

        for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);

        //        addr      bm    set0 wa0      d0        set1 wa1      d1        expected
        tbl[0] = '{17'h00200, 1'b0, 1, 16'h0100, 16'h1234, 0, 16'h0000, 16'h0000, 16'h1234};
        tbl[1] = '{17'h00201, 1'b1, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0012};
        tbl[2] = '{17'h00200, 1'b1, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0034};
        tbl[3] = '{17'h00201, 1'b0, 1, 16'h0100, 16'hAABB, 1, 16'h0101, 16'hCCDD, 16'hDDAA};
        tbl[4] = '{17'h1FFFF, 1'b0, 1, 16'hFFFF, 16'h5566, 1, 16'h0000, 16'h7788, 16'h8855};
        tbl[5] = '{17'h1FFFE, 1'b1, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0066};
        tbl[6] = '{17'h00000, 1'b0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 16'h7788};
        tbl[7] = '{17'h1FFFF, 1'b1, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0055};

        reset = 1'b1; enable = 1'b0; addr = '0; byte_m = 1'b0;
        #1;
        chk("rst NF_CE", 32'(NF_CE), 32'd1);
        chk("rst NF_OE", 32'(NF_OE), 32'd1);
        chk("rst NF_WE", 32'(NF_WE), 32'd1);
        chk("rst NF_BYTE", 32'(NF_BYTE), 32'd1);
        chk("rst NF_A", 32'(NF_A), 32'd0);
        chk("rst rd_data", 32'(rd_data), 32'd0);
        chk("rst ready", 32'(ready), 32'd0);
        repeat (3) @(negedge sys_clk);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            if (tbl[i].set0) mem[tbl[i].wa0] = tbl[i].d0;
            if (tbl[i].set1) mem[tbl[i].wa1] = tbl[i].d1;
            run_read($sformatf("vec%0d", i), tbl[i].a, tbl[i].bm, 1'b0, ed);
            chk($sformatf("vec%0d table_data", i), 32'(rd_data), 32'(tbl[i].exp));
        end

        // Random requests; every fifth one revisits the previous word as a byte read
        ra = '0;
        for (int i = 0; i < 40; i++) begin
            if (i % 5 == 4) begin
                ra = {ra[16:1], 1'($urandom_range(0, 1))};
                rb = 1'b1;
            end else begin
                ra = 17'($urandom_range(0, 17'h1FFFF));
                rb = 1'($urandom_range(0, 1));
            end
            run_read($sformatf("rnd%0d", i), ra, rb, 1'b0, ed);
        end

        // enable held through DONE: result holds, then a changed request starts at once
        run_read("hold", 17'h00404, 1'b0, 1'b1, ed);
        for (int i = 0; i < 3; i++) begin
            @(posedge sys_clk); #1;
            chk($sformatf("hold ready c%0d", i), 32'(ready), 32'd1);
            chk($sformatf("hold data c%0d", i), 32'(rd_data), 32'(ed));
            chk($sformatf("hold ce c%0d", i), 32'(NF_CE), 32'd1);
        end
        run_read("b2b", 17'h00601, 1'b0, 1'b0, ed);

        // enable dropped and request changed during RD0: the latched read still completes
        model_expect(17'h00806, 1'b0, ed, k, k, ra, ra, got);
        model_expect(17'h00806, 1'b0, ed2, k, k, ra, ra, got);
        m_vld = 1'b0;
        model_expect(17'h00806, 1'b0, ed, k, k, ra, ra, got);
        @(negedge sys_clk);
        addr = 17'h00806; byte_m = 1'b0; enable = 1'b1;
        @(posedge sys_clk);
        @(negedge sys_clk);
        enable = 1'b0; addr = 17'h11111; byte_m = 1'b1;
        got = 0; k = 0;
        for (int c = 0; c < 60; c++) begin
            @(posedge sys_clk); #1;
            k++;
            if (ready) begin got = 1; break; end
        end
        chk("drop ready_seen", 32'(got), 32'd1);
        chk("drop latency", 32'(k), 32'(AC + 1));
        chk("drop rd_data", 32'(rd_data), 32'(ed));
        @(posedge sys_clk); #1;
        chk("drop ready_pulse", 32'(ready), 32'd0);
        repeat (3) @(posedge sys_clk);
        #1;
        chk("drop idle_hold", 32'(rd_data), 32'(ed));

        // Reset asserted during the second flash cycle of an odd read
        @(negedge sys_clk);
        addr = 17'h00A01; byte_m = 1'b0; enable = 1'b1;
        repeat (AC + 2) @(posedge sys_clk);
        #1;
        chk("rd1 pre_reset ce", 32'(NF_CE), 32'd0);
        #2 reset = 1'b1;
        #1;
        chk("async rst NF_CE", 32'(NF_CE), 32'd1);
        chk("async rst NF_OE", 32'(NF_OE), 32'd1);
        chk("async rst ready", 32'(ready), 32'd0);
        chk("async rst rd_data", 32'(rd_data), 32'd0);
        m_vld = 1'b0;
        @(negedge sys_clk);
        enable = 1'b0;
        @(negedge sys_clk);
        reset = 1'b0;
        run_read("post_rst", 17'h00200, 1'b0, 1'b0, ed);
        run_read("repeat", 17'h00201, 1'b1, 1'b0, ed);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
